// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port and the shared memory port.
// The arbiter uses the slave modport; the requester/memory side uses master.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [DATA_W-1:0] if_addr_i;
  logic              if_valid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_stall_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [DATA_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_valid_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_stall_o;

  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_re_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i,
    output if_valid_o, if_rdata_o, if_stall_o,
    output dm_valid_o, dm_rdata_o, dm_stall_o,
    output mem_addr_o, mem_wdata_o, mem_re_o, mem_we_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i,
    input  if_valid_o, if_rdata_o, if_stall_o,
    input  dm_valid_o, dm_rdata_o, dm_stall_o,
    input  mem_addr_o, mem_wdata_o, mem_re_o, mem_we_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one fixed-latency memory port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed dm priority.
module mem_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [3:0] CNT_LOAD  = 4'(LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_dm_q, gnt_dm_d;
  logic              we_q, we_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;

  logic              pick_dm;
  logic              do_grant;
  logic              grant_dm;

`ifdef MEM_ARB_RR_EN
  logic last_dm_q, last_dm_d;

  always_comb begin
    if (bus.dm_req_i && bus.if_req_i) pick_dm = !last_dm_q;
    else                              pick_dm = bus.dm_req_i;
  end

  // Only IDLE arbitration counts as a grant decision; hand-overs from DONE do not.
  always_comb begin
    last_dm_d = last_dm_q;
    if (state_q == ST_IDLE && (bus.dm_req_i || bus.if_req_i)) last_dm_d = pick_dm;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) last_dm_q <= 1'b1;
    else        last_dm_q <= last_dm_d;
  end
`else
  always_comb pick_dm = bus.dm_req_i;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_dm_d   = gnt_dm_q;
    we_d       = we_q;
    first_d    = first_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    do_grant   = 1'b0;
    grant_dm   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.if_req_i || bus.dm_req_i) begin
          do_grant = 1'b1;
          grant_dm = pick_dm;
        end
      end
      ST_ACCESS: begin
        first_d = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (gnt_dm_q) begin
            dm_valid_d = 1'b1;
            if (!we_q) dm_rdata_d = bus.mem_rdata_i;
          end else begin
            if_valid_d = 1'b1;
            if (!we_q) if_rdata_d = bus.mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        // The port just served sits out this decision, so the other one cannot starve.
        if (gnt_dm_q && bus.if_req_i) begin
          do_grant = 1'b1;
          grant_dm = 1'b0;
        end else if (!gnt_dm_q && bus.dm_req_i) begin
          do_grant = 1'b1;
          grant_dm = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_grant) begin
      state_d  = ST_ACCESS;
      cnt_d    = CNT_LOAD;
      first_d  = 1'b1;
      gnt_dm_d = grant_dm;
      addr_d   = grant_dm ? bus.dm_addr_i : bus.if_addr_i;
      we_d     = grant_dm && bus.dm_we_i;
      if (grant_dm) wdata_d = bus.dm_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gnt_dm_q   <= 1'b0;
      we_q       <= 1'b0;
      first_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_dm_q   <= gnt_dm_d;
      we_q       <= we_d;
      first_q    <= first_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
    end
  end

  // A write strobes the memory once; a read keeps re asserted for the whole access.
  assign bus.mem_re_o    = (state_q == ST_ACCESS) && !we_q;
  assign bus.mem_we_o    = (state_q == ST_ACCESS) && we_q && first_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;

  assign bus.if_valid_o = if_valid_q;
  assign bus.if_rdata_o = if_rdata_q;
  assign bus.if_stall_o = bus.if_req_i && !if_valid_q;
  assign bus.dm_valid_o = dm_valid_q;
  assign bus.dm_rdata_o = dm_rdata_q;
  assign bus.dm_stall_o = bus.dm_req_i && !dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: LAT=2 main instance plus a LAT=1 throughput instance.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks_total;
  int   checks_passed;

  exp_t if_exp_q[$];
  exp_t dm_exp_q[$];
  exp_t if_e;
  exp_t dm_e;

  logic lat1_prev_re;
  int   lat1_re_pulses;
  int   lat1_valids;
  int   lat1_first_valid;
  int   lat1_c0;

  mem_port_arbiter_if #(.DATA_W(32)) bus ();
  mem_port_arbiter_if #(.DATA_W(32)) bus1 ();

  mem_port_arbiter #(.DATA_W(32), .LAT(2)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  mem_port_arbiter #(.DATA_W(32), .LAT(1)) dut_lat1 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus1)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  assign bus.mem_rdata_i  = mem_model(bus.mem_addr_o);
  assign bus1.mem_rdata_i = mem_model(bus1.mem_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic applyStimulus(input logic if_req, input logic [31:0] if_addr, input logic dm_req,
                               input logic dm_we, input logic [31:0] dm_addr, input logic [31:0] dm_wdata);
    @(posedge clk);
    #1;
    bus.if_req_i   = if_req;
    bus.if_addr_i  = if_addr;
    bus.dm_req_i   = dm_req;
    bus.dm_we_i    = dm_we;
    bus.dm_addr_i  = dm_addr;
    bus.dm_wdata_i = dm_wdata;
  endtask

  // One access on one port: request held through its DONE cycle, then one idle cycle.
  task automatic runSingle(input logic is_dm, input logic is_we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data);
    for (int i = 0; i <= 4; i++) begin
      logic req;
      logic stall;
      req = (i <= 3);
      applyStimulus(req && !is_dm, addr, req && is_dm, is_we, addr, wdata);
      if (i == 0) begin
        if (is_dm) dm_exp_q.push_back('{data: exp_data, cyc: cyc + 3});
        else       if_exp_q.push_back('{data: exp_data, cyc: cyc + 3});
      end
      #3;
      stall = is_dm ? bus.dm_stall_o : bus.if_stall_o;
      if (i <= 3) checkOutput($sformatf("single_stall_c%0d", i), stall, (i <= 2));
      if (i == 1 || i == 2) begin
        checkOutput($sformatf("single_re_c%0d", i), bus.mem_re_o, !is_we);
        checkOutput($sformatf("single_we_c%0d", i), bus.mem_we_o, is_we && (i == 1));
        checkOutput($sformatf("single_addr_c%0d", i), bus.mem_addr_o, addr);
        if (is_we && i == 1) checkOutput("single_wdata", bus.mem_wdata_o, wdata);
      end else begin
        checkOutput($sformatf("single_re_c%0d", i), bus.mem_re_o, 0);
        checkOutput($sformatf("single_we_c%0d", i), bus.mem_we_o, 0);
      end
      if (is_we && i == 3) checkOutput("single_wdata_hold", bus.mem_wdata_o, wdata);
    end
  endtask

  // Both ports read in the same cycle; the winner completes in cycle 3, the other in cycle 6.
  task automatic runTie(input logic dm_first, input logic [31:0] if_addr, input logic [31:0] dm_addr,
                        input logic [31:0] if_data, input logic [31:0] dm_data);
    logic [31:0] first_addr;
    logic [31:0] second_addr;
    first_addr  = dm_first ? dm_addr : if_addr;
    second_addr = dm_first ? if_addr : dm_addr;
    for (int i = 0; i <= 7; i++) begin
      logic ifr;
      logic dmr;
      logic second_stall;
      ifr = dm_first ? (i <= 6) : (i <= 3);
      dmr = dm_first ? (i <= 3) : (i <= 6);
      applyStimulus(ifr, if_addr, dmr, 1'b0, dm_addr, 32'h0);
      if (i == 0) begin
        if_exp_q.push_back('{data: if_data, cyc: cyc + (dm_first ? 6 : 3)});
        dm_exp_q.push_back('{data: dm_data, cyc: cyc + (dm_first ? 3 : 6)});
      end
      #3;
      second_stall = dm_first ? bus.if_stall_o : bus.dm_stall_o;
      if (i <= 6) checkOutput($sformatf("tie_second_stall_c%0d", i), second_stall, (i <= 5));
      if (i == 1 || i == 2 || i == 4 || i == 5) begin
        checkOutput($sformatf("tie_re_c%0d", i), bus.mem_re_o, 1);
        checkOutput($sformatf("tie_addr_c%0d", i), bus.mem_addr_o, (i <= 2) ? first_addr : second_addr);
      end else begin
        checkOutput($sformatf("tie_re_c%0d", i), bus.mem_re_o, 0);
      end
    end
  endtask

  // Scoreboard monitor: every completion pulse must match the oldest expectation for that port.
  always @(negedge clk) begin
    if (bus.if_valid_o === 1'b1) begin
      checkOutput("if_valid_expected", 32'(if_exp_q.size() != 0), 1);
      if (if_exp_q.size() != 0) begin
        if_e = if_exp_q.pop_front();
        checkOutput("if_rdata", bus.if_rdata_o, if_e.data);
        checkOutput("if_valid_cycle", 32'(cyc), 32'(if_e.cyc));
      end
    end
    if (bus.dm_valid_o === 1'b1) begin
      checkOutput("dm_valid_expected", 32'(dm_exp_q.size() != 0), 1);
      if (dm_exp_q.size() != 0) begin
        dm_e = dm_exp_q.pop_front();
        checkOutput("dm_rdata", bus.dm_rdata_o, dm_e.data);
        checkOutput("dm_valid_cycle", 32'(cyc), 32'(dm_e.cyc));
      end
    end
    if (bus1.mem_re_o === 1'b1) begin
      checkOutput("lat1_re_single_cycle", lat1_prev_re, 0);
      if (!lat1_prev_re) lat1_re_pulses++;
    end
    if (bus1.dm_valid_o === 1'b1) begin
      lat1_valids++;
      if (lat1_first_valid < 0) lat1_first_valid = cyc;
      checkOutput("lat1_rdata", bus1.dm_rdata_o, 32'hA5A5_0008);
    end
    lat1_prev_re = (bus1.mem_re_o === 1'b1);
  end

  initial begin
    checks_total     = 0;
    checks_passed    = 0;
    lat1_prev_re     = 1'b0;
    lat1_re_pulses   = 0;
    lat1_valids      = 0;
    lat1_first_valid = -1;
    lat1_c0          = 0;
    rst_n            = 1'b0;
    bus.if_req_i     = 1'b0;
    bus.if_addr_i    = '0;
    bus.dm_req_i     = 1'b0;
    bus.dm_we_i      = 1'b0;
    bus.dm_addr_i    = '0;
    bus.dm_wdata_i   = '0;
    bus1.if_req_i    = 1'b0;
    bus1.if_addr_i   = '0;
    bus1.dm_req_i    = 1'b0;
    bus1.dm_we_i     = 1'b0;
    bus1.dm_addr_i   = '0;
    bus1.dm_wdata_i  = '0;

    $display("[TB] reset");
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #3;
    checkOutput("rst_if_valid", bus.if_valid_o, 0);
    checkOutput("rst_dm_valid", bus.dm_valid_o, 0);
    checkOutput("rst_if_rdata", bus.if_rdata_o, 0);
    checkOutput("rst_dm_rdata", bus.dm_rdata_o, 0);
    checkOutput("rst_mem_addr", bus.mem_addr_o, 0);
    checkOutput("rst_mem_wdata", bus.mem_wdata_o, 0);
    checkOutput("rst_mem_re", bus.mem_re_o, 0);
    checkOutput("rst_mem_we", bus.mem_we_o, 0);
    rst_n = 1'b1;

    $display("[TB] single accesses");
    runSingle(1'b0, 1'b0, 32'h10, 32'h0,  32'hDEADBEEF);
    runSingle(1'b1, 1'b1, 32'h20, 32'h55, 32'h0);
    runSingle(1'b1, 1'b0, 32'h40, 32'h0,  32'hA5A5_0040);
    runSingle(1'b1, 1'b1, 32'h44, 32'h99, 32'hA5A5_0040);

    $display("[TB] simultaneous requests");
`ifdef MEM_ARB_RR_EN
    runTie(1'b0, 32'h10, 32'h80, 32'hDEADBEEF,   32'hA5A5_0080);
    runTie(1'b1, 32'h24, 32'h84, 32'hA5A5_0024, 32'hA5A5_0084);
`else
    runTie(1'b1, 32'h10, 32'h80, 32'hDEADBEEF,   32'hA5A5_0080);
    runTie(1'b1, 32'h24, 32'h84, 32'hA5A5_0024, 32'hA5A5_0084);
`endif

    $display("[TB] reset during access");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    if_exp_q.push_back('{data: 32'hA5A5_0030, cyc: cyc + 3});
    #3;
    checkOutput("abort_if_valid", bus.if_valid_o, 0);
    checkOutput("abort_dm_valid", bus.dm_valid_o, 0);
    checkOutput("abort_mem_re", bus.mem_re_o, 0);
    checkOutput("abort_mem_we", bus.mem_we_o, 0);
    checkOutput("abort_mem_addr", bus.mem_addr_o, 0);
    checkOutput("abort_mem_wdata", bus.mem_wdata_o, 0);
    checkOutput("abort_if_rdata", bus.if_rdata_o, 0);
    checkOutput("abort_dm_rdata", bus.dm_rdata_o, 0);
    for (int i = 1; i <= 2; i++) begin
      applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0);
      #3;
      checkOutput($sformatf("post_rst_re_c%0d", i), bus.mem_re_o, 1);
      checkOutput($sformatf("post_rst_addr_c%0d", i), bus.mem_addr_o, 32'h30);
    end
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] LAT=1 back-to-back data reads");
    @(posedge clk);
    #1;
    bus1.dm_req_i  = 1'b1;
    bus1.dm_addr_i = 32'h8;
    lat1_c0        = cyc;
    repeat (12) @(posedge clk);
    #1;
    bus1.dm_req_i = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    checkOutput("lat1_first_valid_cycle", 32'(lat1_first_valid), 32'(lat1_c0 + 2));
    checkOutput("lat1_valid_per_access", 32'(lat1_valids), 32'(lat1_re_pulses));
    checkOutput("lat1_min_accesses", 32'(lat1_valids >= 3), 1);

    repeat (2) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("if_queue_drained", 32'(if_exp_q.size()), 0);
    checkOutput("dm_queue_drained", 32'(dm_exp_q.size()), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
